// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: the 2-bit
// saturating counter type, its named states and its update rule.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Move one step toward the resolved outcome, holding at either end.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                result = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                result = ctr - 2'd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Direct-mapped array of 2-bit saturating direction counters.
// One asynchronous read port for the fetch lookup and one synchronous
// write port that either trains an existing counter or seeds a newly
// allocated entry as weakly taken.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rdIdx_i,
    output ctr_t             rdCtr_o,
    input  logic             wrEn_i,
    input  logic [IDX_W-1:0] wrIdx_i,
    input  logic             wrAlloc_i,
    input  logic             wrTaken_i
);

    ctr_t ctr_q [ENTRIES];
    ctr_t wrCtr_d;

    assign rdCtr_o = ctr_q[rdIdx_i];

    // New value for the written entry: fresh allocations start weakly taken,
    // hits train toward the resolved outcome.
    always_comb begin
        wrCtr_d = CTR_WT;
        if (!wrAlloc_i) begin
            wrCtr_d = ctr_next(ctr_q[wrIdx_i], wrTaken_i);
        end
    end

    // Counter storage; reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (wrEn_i) begin
            ctr_q[wrIdx_i] <= wrCtr_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit counter direction table plus a tagged
// direct-mapped BTB. Lookup is combinational from registered state with no
// write bypass; training happens one edge after execute resolves a branch.
// Define BP_STATS_EN to add branch / mispredict event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 64,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_f,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] fetchIdx;
    logic [TAG_W-1:0] fetchTag;
    logic             fetchHit;
    ctr_t             fetchCtr;
    logic [31:0]      pcPlus4;

    logic [IDX_W-1:0] updIdx;
    logic [TAG_W-1:0] updTag;
    logic             updHit;

    // PC bits [1:0] never address the tables, and the mispredict flag only
    // feeds the optional counters.
    logic unusedBits;
    assign unusedBits = ^{pc_f[1:0], upd_pc[1:0], upd_mispredict};

    assign fetchIdx = pc_f[IDX_W+1:2];
    assign fetchTag = pc_f[31:IDX_W+2];
    assign updIdx   = upd_pc[IDX_W+1:2];
    assign updTag   = upd_pc[31:IDX_W+2];

    assign fetchHit = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
    assign updHit   = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    assign pcPlus4      = pc_f + 32'd4;
    assign pred_taken   = fetchHit && fetchCtr[1];
    assign pred_target  = fetchHit ? target_q[fetchIdx] : pcPlus4;
    assign pred_next_pc = pred_taken ? pred_target : pcPlus4;

    // Counters train on every resolved branch that hits, and are seeded
    // whenever a taken branch allocates; not-taken misses leave them alone.
    bp_sat_counter_table #(
        .ENTRIES (ENTRIES)
    ) u_ctrTable (
        .clk       (clk),
        .rst       (rst),
        .rdIdx_i   (fetchIdx),
        .rdCtr_o   (fetchCtr),
        .wrEn_i    (upd_valid && (updHit || upd_taken)),
        .wrIdx_i   (updIdx),
        .wrAlloc_i (!updHit),
        .wrTaken_i (upd_taken)
    );

    // BTB storage: taken outcomes refresh the target, and a taken miss
    // claims the slot for its own tag, evicting whatever was there.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            target_q[updIdx] <= upd_target;
            if (!updHit) begin
                valid_q[updIdx] <= 1'b1;
                tag_q[updIdx]   <= updTag;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] statBranches_q;
    logic [31:0] statMispredicts_q;

    // Free-running event counters that wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            statBranches_q    <= '0;
            statMispredicts_q <= '0;
        end else if (upd_valid) begin
            statBranches_q <= statBranches_q + 32'd1;
            if (upd_mispredict) begin
                statMispredicts_q <= statMispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = statBranches_q;
    assign stat_mispredicts = statMispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios checked
// against fixed expectations, then randomized traffic checked against an
// entry-level reference model of the predictor.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: one record per table slot plus event totals.
    bit          refValid  [ENTRIES];
    logic [31:0] refTag    [ENTRIES];
    logic [31:0] refTarget [ENTRIES];
    int          refCtr    [ENTRIES];
    logic [31:0] refBranches;
    logic [31:0] refMispredicts;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES (ENTRIES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(ENTRIES));
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] pc);
        return pc / 32'(4 * ENTRIES);
    endfunction

    task automatic refPredict(input logic [31:0] pc, output logic taken,
                              output logic [31:0] target, output logic [31:0] nextPc);
        int  s;
        bit  hit;
        s      = slotOf(pc);
        hit    = refValid[s] && (refTag[s] == tagOf(pc));
        taken  = hit && (refCtr[s] >= 2);
        target = hit ? refTarget[s] : pc + 32'd4;
        nextPc = taken ? target : pc + 32'd4;
    endtask

    task automatic refUpdate();
        int s;
        bit hit;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                refValid[i]  = 0;
                refTag[i]    = '0;
                refTarget[i] = '0;
                refCtr[i]    = 1;
            end
            refBranches    = '0;
            refMispredicts = '0;
        end else if (upd_valid) begin
            refBranches = refBranches + 32'd1;
            if (upd_mispredict) refMispredicts = refMispredicts + 32'd1;
            s   = slotOf(upd_pc);
            hit = refValid[s] && (refTag[s] == tagOf(upd_pc));
            if (hit && upd_taken) begin
                refCtr[s]    = (refCtr[s] == 3) ? 3 : refCtr[s] + 1;
                refTarget[s] = upd_target;
            end else if (hit) begin
                refCtr[s] = (refCtr[s] == 0) ? 0 : refCtr[s] - 1;
            end else if (upd_taken) begin
                refValid[s]  = 1;
                refTag[s]    = tagOf(upd_pc);
                refTarget[s] = upd_target;
                refCtr[s]    = 2;
            end
        end
    endtask

    // Drive one cycle's inputs just after a falling edge and let them settle.
    task automatic applyStimulus(input logic r, input logic [31:0] pcf, input logic uv,
                                 input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic um);
        rst            = r;
        pc_f           = pcf;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        refUpdate();
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] pcf);
        applyStimulus(1'b0, pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] randPc();
        logic [31:0] pc;
        if ($urandom_range(0, 15) == 0) begin
            pc = 32'hFFFF_FFFC;
        end else begin
            pc = 32'h0000_1000 + 32'(4 * $urandom_range(0, 5))
                 + 32'(4 * ENTRIES * $urandom_range(0, 2));
        end
        return pc + 32'($urandom_range(0, 3));
    endfunction

    task automatic test_reset();
        applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
        tick();
        lookup(32'h0000_0100);
        nChecks++;
        if (pred_taken !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset_taken: got %0b expected 0", pred_taken);
        end
        nChecks++;
        if (pred_target !== 32'h104) begin
            nFails++; $display("[TB] FAIL reset_target: got %h expected 00000104", pred_target);
        end
        nChecks++;
        if (pred_next_pc !== 32'h104) begin
            nFails++; $display("[TB] FAIL reset_next: got %h expected 00000104", pred_next_pc);
        end
`ifdef BP_STATS_EN
        nChecks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            nFails++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0",
                               stat_branches, stat_mispredicts);
        end
`endif
        lookup(32'hFFFF_FFFC);
        nChecks++;
        if (pred_next_pc !== 32'h0) begin
            nFails++; $display("[TB] FAIL wrap_next: got %h expected 00000000", pred_next_pc);
        end
    endtask

    task automatic test_single_update();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0);
        tick();
        lookup(32'h100);
        nChecks++;
        if (pred_taken !== 1'b1) begin
            nFails++; $display("[TB] FAIL alloc_taken: got %0b expected 1", pred_taken);
        end
        nChecks++;
        if (pred_target !== 32'h40) begin
            nFails++; $display("[TB] FAIL alloc_target: got %h expected 00000040", pred_target);
        end
        nChecks++;
        if (pred_next_pc !== 32'h40) begin
            nFails++; $display("[TB] FAIL alloc_next: got %h expected 00000040", pred_next_pc);
        end
    endtask

    task automatic test_counter_saturation();
        logic        expTaken;
        logic [31:0] expNext;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, (k >= 3), 32'h40, 1'b0);
            tick();
            lookup(32'h100);
            expTaken = (k == 4);
            expNext  = expTaken ? 32'h40 : 32'h104;
            nChecks++;
            if (pred_taken !== expTaken || pred_next_pc !== expNext || pred_target !== 32'h40) begin
                nFails++;
                $display("[TB] FAIL ctr_step%0d: got taken=%0b next=%h target=%h expected taken=%0b next=%h target=00000040",
                         k, pred_taken, pred_next_pc, pred_target, expTaken, expNext);
            end
        end
    endtask

    task automatic test_aliasing();
        logic [31:0] pc;
        pc = 32'h100 + 32'(4 * ENTRIES);
        lookup(pc);
        nChecks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== pc + 32'd4 || pred_target !== pc + 32'd4) begin
            nFails++;
            $display("[TB] FAIL alias: got taken=%0b next=%h target=%h expected taken=0 next=%h",
                     pred_taken, pred_next_pc, pred_target, pc + 32'd4);
        end
    endtask

    task automatic test_same_cycle();
        applyStimulus(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0);
        nChecks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h204) begin
            nFails++;
            $display("[TB] FAIL same_cycle_old: got taken=%0b next=%h expected taken=0 next=00000204",
                     pred_taken, pred_next_pc);
        end
        tick();
        lookup(32'h200);
        nChecks++;
        if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) begin
            nFails++;
            $display("[TB] FAIL same_cycle_new: got taken=%0b next=%h expected taken=1 next=00000080",
                     pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_reset_drops_update();
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h300, 1'b1, 32'h90, 1'b1);
        tick();
        lookup(32'h300);
        nChecks++;
        if (pred_taken !== 1'b0 || pred_next_pc !== 32'h304) begin
            nFails++;
            $display("[TB] FAIL rst_drop: got taken=%0b next=%h expected taken=0 next=00000304",
                     pred_taken, pred_next_pc);
        end
        lookup(32'h200);
        nChecks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
            nFails++;
            $display("[TB] FAIL rst_clear: got taken=%0b target=%h expected taken=0 target=00000204",
                     pred_taken, pred_target);
        end
`ifdef BP_STATS_EN
        nChecks++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            nFails++; $display("[TB] FAIL rst_stats: got %0d/%0d expected 0/0",
                               stat_branches, stat_mispredicts);
        end
`endif
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        logic misp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h400 + 32'(8 * k), k[0], 32'h10, misp[k]);
            tick();
        end
        lookup(32'h0);
        nChecks++;
        if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            nFails++; $display("[TB] FAIL stats_count: got %0d/%0d expected 5/2",
                               stat_branches, stat_mispredicts);
        end
    endtask
`endif

    task automatic test_random();
        logic        expTaken;
        logic [31:0] expTarget;
        logic [31:0] expNext;
        int          bad;
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        bad = 0;
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 79) == 0), randPc(), 1'($urandom_range(0, 1)),
                          randPc(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            refPredict(pc_f, expTaken, expTarget, expNext);
            nChecks++;
            if (pred_taken !== expTaken) begin
                nFails++;
                if (bad++ < 10) $display("[TB] FAIL rand_taken pc=%h: got %0b expected %0b", pc_f, pred_taken, expTaken);
            end
            nChecks++;
            if (pred_target !== expTarget) begin
                nFails++;
                if (bad++ < 10) $display("[TB] FAIL rand_target pc=%h: got %h expected %h", pc_f, pred_target, expTarget);
            end
            nChecks++;
            if (pred_next_pc !== expNext) begin
                nFails++;
                if (bad++ < 10) $display("[TB] FAIL rand_next pc=%h: got %h expected %h", pc_f, pred_next_pc, expNext);
            end
            tick();
        end
`ifdef BP_STATS_EN
        lookup(32'h0);
        nChecks++;
        if (stat_branches !== refBranches || stat_mispredicts !== refMispredicts) begin
            nFails++; $display("[TB] FAIL rand_stats: got %0d/%0d expected %0d/%0d",
                               stat_branches, stat_mispredicts, refBranches, refMispredicts);
        end
`endif
    endtask

    initial begin
        applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        test_reset();
        test_single_update();
        test_counter_saturation();
        test_aliasing();
        test_same_cycle();
        test_reset_drops_update();
`ifdef BP_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
